// File: rtl/right_funnel_shifter_seq.sv
// ============================================================================
// Module   : right_funnel_shifter_seq
// Brief    : Multi-cycle right funnel shifter, y = ({in1,in2} >> amt)[WIDTH-1:0],
//            one bit per clock. Define ROTATE_EN to add the rot port (rotate in1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module right_funnel_shifter_seq #(
    parameter int WIDTH = 10,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
`ifdef ROTATE_EN
    ,
    input  logic             rot
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam int         c_SPAN  = 2 * WIDTH;

    logic [1:0]         r_state;
    logic [c_SPAN-1:0]  r_sr;
    logic [AMT_W-1:0]   r_cnt;
    logic               r_rot_mode;

    logic               w_rot_req;
    logic               w_accept;
    logic [c_SPAN-1:0]  w_shifted;
    logic [c_SPAN-1:0]  w_window;
    logic [AMT_W-1:0]   w_start_cnt;

`ifdef ROTATE_EN
    assign w_rot_req = rot;
`else
    assign w_rot_req = 1'b0;
`endif

    assign w_accept  = in_valid && in_ready && (r_state == S_IDLE);
    assign w_window  = w_rot_req ? {in1, in1} : {in1, in2};
    assign w_shifted = {(r_rot_mode ? r_sr[0] : 1'b0), r_sr[c_SPAN-1:1]};

    // Shifting past the whole window only empties it, so the count is clamped;
    // rotation wraps instead and keeps the raw amount.
    assign w_start_cnt = (!w_rot_req && (int'(amt) >= c_SPAN)) ? AMT_W'(c_SPAN) : amt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_rot_mode <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            y          <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sr       <= w_window;
                        r_cnt      <= w_start_cnt;
                        r_rot_mode <= w_rot_req;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= (amt == '0) ? S_DONE : S_SHIFT;
                    end else begin
                        in_ready   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_shifted;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        y         <= w_shifted[WIDTH-1:0];
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A zero-amount op arrives here without a result yet; publish it
                    // one edge later so its latency matches a single-bit shift.
                    if (!out_valid) begin
                        y         <= r_sr[WIDTH-1:0];
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
